// File: rtl/red_circle_motion_ctrl_if.sv
// Frame strobe, raw gamepad levels and sprite-position outputs of the red circle controller.
interface red_circle_motion_ctrl_if;
  logic       frame_start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_center;
  logic [9:0] red_circle_x;
  logic [8:0] red_circle_y;
  logic       moving;
  logic       pos_valid;
  logic       overrun;

  modport master (
    output frame_start, btn_up, btn_down, btn_left, btn_right, btn_center,
    input  red_circle_x, red_circle_y, moving, pos_valid, overrun
  );

  modport slave (
    input  frame_start, btn_up, btn_down, btn_left, btn_right, btn_center,
    output red_circle_x, red_circle_y, moving, pos_valid, overrun
  );
endinterface

// File: rtl/red_circle_motion_ctrl.sv
// Once-per-frame red circle position update: sample buttons, ramp speed, step, clamp, commit.
// Outputs only change on the commit edge, four cycles after frame_start is seen.
module red_circle_motion_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned RADIUS      = 8,
  parameter int unsigned START_X     = 320,
  parameter int unsigned START_Y     = 240,
  parameter int unsigned BASE_SPEED  = 1,
  parameter int unsigned MAX_SPEED   = 4,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  red_circle_motion_ctrl_if.slave  bus
);

  localparam int unsigned HoldW = 8;
  localparam logic signed [11:0] XMin = 12'(RADIUS);
  localparam logic signed [11:0] XMax = 12'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [11:0] YMin = 12'(RADIUS);
  localparam logic signed [11:0] YMax = 12'(SCREEN_H - 1 - RADIUS);
  localparam logic [HoldW-1:0]   HoldMax = '1;

  typedef enum logic [2:0] {StIdle, StSample, StCalc, StClamp, StCommit} state_e;

  state_e state_q, state_d;

  // Button vectors are packed {center, right, left, down, up}.
  logic [4:0]         btn_raw, btn_meta_q, btn_sync_q, btn_q, btn_d;
  logic [HoldW-1:0]   hold_q, hold_d, hold_steps;
  logic [11:0]        speed_q, speed_d, speed_raw;
  logic signed [11:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic signed [11:0] dx, dy;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic               moving_q, moving_d;
  logic               pos_valid_q, pos_valid_d;
  logic               overrun_q, overrun_d;
  logic               any_dir;

  assign btn_raw = {bus.btn_center, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.frame_start) state_d = StSample;
      StSample: state_d = StCalc;
      StCalc:   state_d = StClamp;
      StClamp:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Speed uses the hold count before this frame's increment.
  assign hold_steps = HoldW'(hold_q / HoldW'(HOLD_FRAMES));
  assign speed_raw  = 12'(BASE_SPEED) + {4'b0000, hold_steps};
  assign any_dir    = |btn_sync_q[3:0];

  always_comb begin
    if (btn_q[3] && !btn_q[2])      dx = $signed(speed_q);
    else if (btn_q[2] && !btn_q[3]) dx = -$signed(speed_q);
    else                            dx = '0;
    if (btn_q[1] && !btn_q[0])      dy = $signed(speed_q);
    else if (btn_q[0] && !btn_q[1]) dy = -$signed(speed_q);
    else                            dy = '0;
  end

  always_comb begin
    btn_d       = btn_q;
    hold_d      = hold_q;
    speed_d     = speed_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    x_d         = x_q;
    y_d         = y_q;
    moving_d    = moving_q;
    pos_valid_d = 1'b0;
    overrun_d   = overrun_q | (bus.frame_start && (state_q != StIdle));

    unique case (state_q)
      StSample: begin
        btn_d   = btn_sync_q;
        speed_d = (speed_raw > 12'(MAX_SPEED)) ? 12'(MAX_SPEED) : speed_raw;
        // A recentre frame leaves the counter alone; the commit clears it.
        if (!btn_sync_q[4]) begin
          if (any_dir) hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
          else         hold_d = '0;
        end
      end
      StCalc: begin
        if (btn_q[4]) begin
          cand_x_d = $signed(12'(START_X));
          cand_y_d = $signed(12'(START_Y));
        end else begin
          cand_x_d = $signed({2'b00, x_q}) + dx;
          cand_y_d = $signed({3'b000, y_q}) + dy;
        end
      end
      StClamp: begin
        if (cand_x_q < XMin)      cand_x_d = XMin;
        else if (cand_x_q > XMax) cand_x_d = XMax;
        if (cand_y_q < YMin)      cand_y_d = YMin;
        else if (cand_y_q > YMax) cand_y_d = YMax;
      end
      StCommit: begin
        x_d         = cand_x_q[9:0];
        y_d         = cand_y_q[8:0];
        moving_d    = (cand_x_q[9:0] != x_q) || (cand_y_q[8:0] != y_q);
        pos_valid_d = 1'b1;
        if (btn_q[4]) hold_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_q       <= '0;
      hold_q      <= '0;
      speed_q     <= '0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      x_q         <= 10'(START_X);
      y_q         <= 9'(START_Y);
      moving_q    <= 1'b0;
      pos_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      btn_q       <= btn_d;
      hold_q      <= hold_d;
      speed_q     <= speed_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      moving_q    <= moving_d;
      pos_valid_q <= pos_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.red_circle_x = x_q;
  assign bus.red_circle_y = y_q;
  assign bus.moving       = moving_q;
  assign bus.pos_valid    = pos_valid_q;
  assign bus.overrun      = overrun_q;

endmodule
